// File: rtl/extbus_seq.sv
`default_nettype none
// ============================================================================
//  Module   : extbus_seq
//  Purpose  : Memory-transaction sequencer for the X port of the 4 x 72-bit
//             external bus register file. A load fetches a 72-bit word
//             (64 data + 8 tag) from memory and writes it into a register
//             word. A store reads a register word out through X and writes
//             it to memory.
//  Ports    : clk/reset       - clock, synchronous active-high reset
//             cmd_*           - microcode command handshake (valid/ready)
//             done/err        - completion pulse / timeout pulse
//             mem_*           - memory request interface (req held to ack)
//             ax/ecx/wx/dx    - X port address, read enable, write enable, data
//             odx             - X port read data, valid while ecx=1
//  Revision : 1.0 - initial release
// ============================================================================
module extbus_seq #(
    parameter int AW      = 20,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_reg,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [71:0]   mem_wdata,
    input  logic [71:0]   mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    ax,
    output logic          ecx,
    output logic          wx,
    output logic [71:0]   dx,
    input  logic [71:0]   odx
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XRD  = 3'd1,
        S_REQ  = 3'd2,
        S_XWR  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_addr,  w_addr_nxt;
    logic [1:0]    r_reg,   w_reg_nxt;
    logic          r_wr,    w_wr_nxt;
    logic [71:0]   r_data,  w_data_nxt;
    logic          r_err,   w_err_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;

    // Next-state and next held-register values. Outputs are registered from
    // these "next" values so every output is a flop yet already reflects the
    // state it belongs to in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_reg_nxt   = r_reg;
        w_wr_nxt    = r_wr;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt  = cmd_addr;
                    w_reg_nxt   = cmd_reg;
                    w_wr_nxt    = cmd_write;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = cmd_write ? S_XRD : S_REQ;
                end
            end
            S_XRD: begin
                w_data_nxt  = odx;
                w_cnt_nxt   = '0;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (mem_ack) begin
                    if (!r_wr) begin
                        w_data_nxt  = mem_rdata;
                        w_state_nxt = S_XWR;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else if ((TIMEOUT != 0) && (r_cnt == C_TMO_LAST)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_XWR:   w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_reg     <= '0;
            r_wr      <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ax        <= '0;
            ecx       <= 1'b0;
            wx        <= 1'b0;
            dx        <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_reg     <= w_reg_nxt;
            r_wr      <= w_wr_nxt;
            r_data    <= w_data_nxt;
            r_err     <= w_err_nxt;
            r_cnt     <= w_cnt_nxt;
            cmd_ready <= (w_state_nxt == S_IDLE);
            done      <= (w_state_nxt == S_FIN);
            err       <= (w_state_nxt == S_FIN) && w_err_nxt;
            mem_req   <= (w_state_nxt == S_REQ);
            mem_we    <= (w_state_nxt == S_REQ) && w_wr_nxt;
            mem_addr  <= (w_state_nxt == S_REQ) ? w_addr_nxt : '0;
            mem_wdata <= ((w_state_nxt == S_REQ) && w_wr_nxt) ? w_data_nxt : '0;
            ax        <= ((w_state_nxt == S_XRD) || (w_state_nxt == S_XWR)) ? w_reg_nxt : 2'd0;
            ecx       <= (w_state_nxt == S_XRD);
            wx        <= (w_state_nxt == S_XWR);
            dx        <= (w_state_nxt == S_XWR) ? w_data_nxt : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_extbus_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_extbus_seq
//  Purpose  : Directed self-checking bench for extbus_seq (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_extbus_seq;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_reg;
    logic          done, err;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [71:0]   mem_wdata, mem_rdata;
    logic [1:0]    ax;
    logic          ecx, wx;
    logic [71:0]   dx, odx;

    logic [71:0]   rf [4];

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [71:0] C_LOAD_DATA  = 72'hA5_0123456789ABCDEF;
    localparam logic [71:0] C_STORE_DATA = 72'h3C_FEDCBA9876543210;
    localparam logic [71:0] C_B2B_DATA   = 72'h11_2233445566778899;

    extbus_seq #(.AW(AW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_reg   (cmd_reg),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ax        (ax),
        .ecx       (ecx),
        .wx        (wx),
        .dx        (dx),
        .odx       (odx)
    );

    always #5 clk = ~clk;

    // Register file read model: data only while the X port is enabled.
    always_comb begin
        odx = ecx ? rf[ax] : 72'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rf[0] = 72'h00_0000000000000F00;
        rf[1] = C_STORE_DATA;
        rf[2] = 72'h22_2222222222222222;
        rf[3] = 72'h33_3333333333333333;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_reg = 2'd0; mem_ack = 1'b0; mem_rdata = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_ready",   cmd_ready, 0);
        chk("rst_done",    done,      0);
        chk("rst_memreq",  mem_req,   0);
        chk("rst_xport",   {ax, ecx, wx}, 0);
        chk("rst_dx",      dx,        0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        // ---- load, ack in 4th REQ cycle (also the ack/timeout tie) ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h01234; cmd_reg = 2'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("ld_memreq", mem_req, 1);
            chk("ld_addr",   mem_addr, 72'h01234);
            chk("ld_we",     mem_we, 0);
            chk("ld_ready",  cmd_ready, 0);
            mem_ack   = (i == 4);
            mem_rdata = (i == 4) ? C_LOAD_DATA : 72'd0;
            tick();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        chk("ld_wx",     wx, 1);
        chk("ld_ax",     ax, 2);
        chk("ld_dx",     dx, C_LOAD_DATA);
        chk("ld_ecx",    ecx, 0);
        chk("ld_req_off", mem_req, 0);
        tick();
        chk("ld_done",   done, 1);
        chk("ld_err",    err, 0);
        chk("ld_wx_off", wx, 0);
        tick();
        chk("ld_ready_back", cmd_ready, 1);
        chk("ld_done_off",   done, 0);

        // ---- store ----
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h0ABCD; cmd_reg = 2'd1;
        tick();
        cmd_valid = 1'b0;
        chk("st_ecx",    ecx, 1);
        chk("st_ax",     ax, 1);
        chk("st_wx",     wx, 0);
        chk("st_req0",   mem_req, 0);
        tick();
        for (int i = 1; i <= 2; i++) begin
            chk("st_memreq", mem_req, 1);
            chk("st_we",     mem_we, 1);
            chk("st_addr",   mem_addr, 72'h0ABCD);
            chk("st_wdata",  mem_wdata, C_STORE_DATA);
            chk("st_wx_req", wx, 0);
            mem_ack = (i == 2);
            tick();
        end
        mem_ack = 1'b0;
        chk("st_done",   done, 1);
        chk("st_err",    err, 0);
        chk("st_wx_fin", wx, 0);
        tick();
        chk("st_ready_back", cmd_ready, 1);

        // ---- timeout: no ack ever ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00FFF; cmd_reg = 2'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("to_memreq", mem_req, 1);
            chk("to_done_early", done, 0);
            tick();
        end
        chk("to_req_off", mem_req, 0);
        chk("to_done",    done, 1);
        chk("to_err",     err, 1);
        chk("to_wx",      wx, 0);
        tick();
        chk("to_ready",   cmd_ready, 1);
        chk("to_err_off", err, 0);

        // ---- back-to-back with cmd_valid held high ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00010; cmd_reg = 2'd0;
        tick();
        cmd_write = 1'b1; cmd_reg = 2'd1; cmd_addr = 20'h00020;
        chk("bb_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = C_B2B_DATA;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("bb_wx",    wx, 1);
        chk("bb_dx",    dx, C_B2B_DATA);
        chk("bb_ax",    ax, 0);
        chk("bb_busy1", cmd_ready, 0);
        tick();
        chk("bb_done",  done, 1);
        chk("bb_busy2", cmd_ready, 0);
        chk("bb_noecx", ecx, 0);
        tick();
        chk("bb_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("bb2_ecx", ecx, 1);
        chk("bb2_ax",  ax, 1);
        tick();
        chk("bb2_we",    mem_we, 1);
        chk("bb2_addr",  mem_addr, 72'h00020);
        chk("bb2_wdata", mem_wdata, C_STORE_DATA);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("bb2_done", done, 1);
        tick();
        chk("bb2_ready", cmd_ready, 1);

        // ---- stray ack in IDLE ----
        mem_ack = 1'b1; mem_rdata = 72'hFF_FFFFFFFFFFFFFFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stray_ready", cmd_ready, 1);
        chk("stray_state", {mem_req, wx, ecx, done}, 0);

        // ---- reset in the middle of REQ ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00777; cmd_reg = 2'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mr_req", mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_req_off", mem_req, 0);
        chk("mr_ready",   cmd_ready, 0);
        chk("mr_done",    done, 0);
        tick();
        chk("mr_ready_back", cmd_ready, 1);
        chk("mr_nodone",     {done, wx, mem_req}, 0);
        mem_ack = 1'b1; mem_rdata = C_LOAD_DATA;
        tick();
        mem_ack = 1'b0;
        chk("mr_idle_ack", {done, wx, mem_req}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/extbus_seq.md
Name: extbus_seq

Overview:
- Sequencer for memory transactions that drives the X port of the 4-word x 72-bit external bus register file.
- On a microcode command it either:
  - fetches a 72-bit word (64 data + 8 tag) from main memory and writes it into a selected external bus word, or
  - reads a selected word out through port X and stores it to memory.
- Sits between the microcode control unit / memory arbiter and the external bus register file.

Parameters:
- AW, 20, memory address width.
- TIMEOUT, 255, maximum cycles spent in REQ waiting for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = register-to-memory store, 0 = memory-to-register load
- cmd_addr  in  AW  memory word address
- cmd_reg  in  2  external bus word index
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with done
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write strobe qualifier
- mem_addr  out  AW  memory address
- mem_wdata  out  72  store data
- mem_rdata  in  72  load data, valid when mem_ack=1
- mem_ack  in  1  memory acknowledge
- ax  out  2  X port address
- ecx  out  1  X port enable (read out)
- wx  out  1  X port write enable
- dx  out  72  data into X port
- odx  in  72  data out of X port, valid combinationally while ecx=1

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous and active-high.
  - All outputs are registered (Moore), driven from state and held registers.
  - Reset values:
    - cmd_ready=0 during reset, then 1 from the first cycle after reset.
    - All other outputs 0: done, err, mem_req, mem_we, mem_addr, mem_wdata, ax, ecx, wx, dx.
    - state=IDLE, timeout counter=0.
- States: IDLE, XRD, REQ, XWR, FIN.
- IDLE
  - cmd_ready=1.
  - On accept, latch cmd_addr, cmd_reg and cmd_write.
  - Next state: XRD if cmd_write=1, otherwise REQ.
  - cmd_valid while not in IDLE is ignored; commands never queue.
- XRD (one cycle)
  - Drives ax=reg, ecx=1, wx=0.
  - Captures odx into the data register at the end of the cycle.
  - Next state: REQ.
- REQ
  - Drives mem_req=1, mem_we=cmd_write and mem_addr=latched address.
  - mem_wdata = captured data on a store, 0 on a load.
  - mem_addr and mem_wdata stay stable for the whole REQ phase.
  - Counter clears on REQ entry and increments each REQ cycle that has mem_ack=0.
  - mem_ack=1:
    - On a load, capture mem_rdata.
    - Next state: XWR for a load, FIN for a store.
  - mem_ack=0 with counter==TIMEOUT-1 and TIMEOUT!=0:
    - Next state FIN with the error flag set.
    - No X write occurs.
  - mem_ack and the timeout condition in the same cycle: ack wins.
  - mem_ack outside REQ is ignored.
- XWR (one cycle)
  - Drives ax=reg, dx=loaded data, wx=1, ecx=0.
  - Next state: FIN.
- FIN (one cycle)
  - done=1; err=1 only if timed out.
  - Next state: IDLE.
- Latency (accept at cycle 0, ack arriving k cycles after REQ entry, ack present in REQ cycle k+1):
  - Load:
    - REQ from cycle 1; ack in cycle k+1.
    - wx in cycle k+2, done in cycle k+3.
    - cmd_ready in cycle k+4.
  - Store:
    - ecx in cycle 1.
    - REQ from cycle 2; ack in cycle k+2; done in cycle k+3.
  - Zero-wait ack (k=0): load = 4 cycles accept-to-ready, store = 4.
- Exclusivity: ecx and wx are never 1 in the same cycle; outside XRD/XWR ax=0 and dx=0.
- Reset mid-operation:
  - Next edge forces IDLE and drops mem_req and wx.
  - No done pulse; captured data is discarded.

Test Plan:
- Load: cmd_write=0, cmd_addr=0x01234, cmd_reg=2; memory acks 3 cycles after REQ entry with rdata=0xA5_0123456789ABCDEF -> mem_req held 4 cycles at addr 0x01234 with mem_we=0; then wx=1, ax=2, dx=0xA5_0123456789ABCDEF for one cycle; done next cycle; err=0.
- Store: cmd_write=1, cmd_reg=1; odx model returns 0x3C_FEDCBA9876543210 for ax=1 -> ecx one cycle, then mem_req=1, mem_we=1, mem_wdata=0x3C_FEDCBA9876543210 until ack; done=1, wx never asserted.
- Timeout: TIMEOUT=4, load, mem_ack never asserted -> mem_req high exactly 4 cycles, then done=1 and err=1 together; no wx; cmd_ready next cycle.
- Ack-versus-timeout tie: TIMEOUT=4, ack in the 4th REQ cycle -> treated as success: err=0 and XWR occurs.
- Back-to-back and ignored commands: cmd_valid held high with alternating cmd_write -> second command accepted only on the cycle cmd_ready=1 after FIN; cmd_valid pulses while busy are ignored; stray mem_ack in IDLE causes no state change.
- Reset mid-REQ: assert reset for 1 cycle during REQ -> mem_req=0 and state IDLE on the next edge; no done; cmd_ready=1 the cycle after reset deasserts.
